// File: rtl/crossbar_pkg.sv
// Shared crossbar types and constants used by the TX port schedulers.
package crossbar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } sched_state_e;

  localparam int C_DEFAULT_IFG = 12;

endpackage

// File: rtl/tx_port_scheduler_rr_pick.sv
// Combinational round-robin picker: searches from last+1 (wrapping) for the
// first active request and returns it one-hot and as an index.
module rr_pick #(
  parameter int P_WIDTH = 3,
  parameter int P_IDX_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1
) (
  input  logic [P_WIDTH-1:0] req_i,
  input  logic [P_IDX_W-1:0] last_i,
  output logic [P_WIDTH-1:0] winner_o,
  output logic [P_IDX_W-1:0] win_idx_o
);

  logic               w_found;
  logic [P_IDX_W-1:0] w_idx;

  always_comb begin
    winner_o  = '0;
    win_idx_o = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    // Offset P_WIDTH wraps back to last itself, so it is checked last.
    for (int k = 1; k <= P_WIDTH; k++) begin
      w_idx = P_IDX_W'((int'(last_i) + k) % P_WIDTH);
      if (!w_found && req_i[w_idx]) begin
        w_found         = 1'b1;
        winner_o[w_idx] = 1'b1;
        win_idx_o       = w_idx;
      end
    end
  end

endmodule

// File: rtl/tx_port_scheduler.sv
// Frame-aware TX port scheduler: grants one VC for a whole frame, pops bytes
// while it has data, then holds the port idle for P_IFG cycles after eof.
module tx_port_scheduler
  import crossbar_pkg::*;
#(
  parameter int P_WIDTH     = 3,
  parameter int P_IFG       = C_DEFAULT_IFG,
  parameter int P_LEN_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [P_WIDTH-1:0]     vc_empty_i,
  input  logic [P_WIDTH-1:0]     vc_eof_i,
  output logic [P_WIDTH-1:0]     vc_read_o,
  output logic [P_WIDTH-1:0]     grant_o,
  output logic                   tx_valid_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [P_LEN_WIDTH-1:0] frame_len_o
);

  localparam int IW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam int GW = (P_IFG > 0) ? $clog2(P_IFG + 1) : 1;
  localparam logic [IW-1:0] C_LAST_RST = IW'(P_WIDTH - 1);
  localparam logic [GW-1:0] C_GAP_LOAD = GW'(P_IFG);

  sched_state_e           r_state;
  sched_state_e           w_state_next;
  logic [P_WIDTH-1:0]     r_grant;
  logic [IW-1:0]          r_last;
  logic [GW-1:0]          r_gap;
  logic [P_LEN_WIDTH-1:0] r_len;
  logic [P_LEN_WIDTH-1:0] r_frame_len;
  logic                   r_done;

  logic [P_WIDTH-1:0]     w_req;
  logic [P_WIDTH-1:0]     w_win;
  logic [IW-1:0]          w_win_idx;
  logic                   w_pop;
  logic                   w_eof_pop;
  logic [P_LEN_WIDTH-1:0] w_len_inc;

  function automatic logic [P_LEN_WIDTH-1:0] sat_inc(input logic [P_LEN_WIDTH-1:0] v);
    return (&v) ? v : v + P_LEN_WIDTH'(1);
  endfunction

  assign w_req      = ~vc_empty_i;
  assign vc_read_o  = (r_state == S_SEND) ? (r_grant & ~vc_empty_i) : '0;
  assign w_pop      = |vc_read_o;
  assign w_eof_pop  = |(vc_read_o & vc_eof_i);
  assign w_len_inc  = sat_inc(r_len);

  assign tx_valid_o   = w_pop;
  assign grant_o      = r_grant;
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = r_done;
  assign frame_len_o  = r_frame_len;

  rr_pick #(
    .P_WIDTH (P_WIDTH),
    .P_IDX_W (IW)
  ) u_rr_pick (
    .req_i     (w_req),
    .last_i    (r_last),
    .winner_o  (w_win),
    .win_idx_o (w_win_idx)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|w_req) w_state_next = S_SEND;
      S_SEND:  if (w_eof_pop) w_state_next = (P_IFG == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gap <= GW'(1)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An underrun stall simply produces no pop: grant, last and len all hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_grant     <= '0;
      r_last      <= C_LAST_RST;
      r_gap       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_frame_len <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_grant <= w_win;
            r_last  <= w_win_idx;
            r_len   <= '0;
          end
        end
        S_SEND: begin
          if (w_pop) begin
            r_len <= w_len_inc;
            if (w_eof_pop) begin
              r_frame_len <= w_len_inc;
              r_done      <= 1'b1;
              r_grant     <= '0;
              r_gap       <= C_GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          r_gap <= r_gap - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
